// File: rtl/parity_frame_accum.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_accum
// Description : Streaming frame parity generator. Each accepted DATA_W-bit
//               word is XOR-reduced to one bit. These bits are accumulated
//               over a frame that ends on in_last_i. The frame parity, the
//               saturating beat count and an overflow flag are returned on a
//               valid/ready result port. The result appears one cycle after
//               the closing beat.
// Options     : PARITY_CHECK_EN (macro) adds in_exp_parity_i / out_err_o. These
//               compare the generated parity with an expected parity bit that
//               is supplied with the closing beat.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_accum #(
  parameter int DATA_W    = 8,
  parameter int ODD       = 0,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
`ifdef PARITY_CHECK_EN
  input  logic              in_exp_parity_i,
  output logic              out_err_o,
`endif
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_parity_o,
  output logic [CNT_W-1:0]  out_beats_o,
  output logic              out_overflow_o
);

  localparam logic [CNT_W-1:0] C_MAX_BEATS = CNT_W'(MAX_BEATS);
  localparam logic             C_ODD       = (ODD != 0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             out_valid_q, out_valid_d;
  logic             out_parity_q, out_parity_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;
  logic             out_ovf_q, out_ovf_d;
`ifdef PARITY_CHECK_EN
  logic             out_err_q, out_err_d;
`endif

  // Handshake qualifiers and per-beat values.
  logic             w_in_ready;
  logic             w_in_acc;
  logic             w_out_acc;
  logic             w_close;
  logic             w_beat_par;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_ovf_inc;
  logic             w_frame_par;

  // A slot is free when no result is held, or when the held result leaves this cycle.
  assign w_in_ready  = !out_valid_q | out_ready_i;
  assign w_in_acc    = in_valid_i & w_in_ready;
  assign w_out_acc   = out_valid_q & out_ready_i;
  assign w_close     = w_in_acc & in_last_i;
  assign w_beat_par  = ^in_data_i;
  assign w_cnt_sat   = (cnt_q == C_MAX_BEATS);
  assign w_cnt_inc   = w_cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
  assign w_ovf_inc   = ovf_q | w_cnt_sat;
  assign w_frame_par = acc_q ^ w_beat_par ^ C_ODD;

  // Frame-open tracking. The datapath below does the accumulation. This FSM
  // records whether beats of an unfinished frame are currently held.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (w_in_acc && !in_last_i) state_d = S_ACC;
      S_ACC:  if (w_close)                state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // Accumulator, beat counter and sticky overflow for the open frame.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (w_close) begin
      acc_d = 1'b0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (w_in_acc) begin
      acc_d = acc_q ^ w_beat_par;
      cnt_d = w_cnt_inc;
      ovf_d = w_ovf_inc;
    end
  end

  // Result register. A new close wins over draining, so back-to-back frames
  // keep out_valid high. Otherwise the fields hold until they are accepted.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_parity_d = out_parity_q;
    out_beats_d  = out_beats_q;
    out_ovf_d    = out_ovf_q;
`ifdef PARITY_CHECK_EN
    out_err_d    = out_err_q;
`endif
    if (w_close) begin
      out_valid_d  = 1'b1;
      out_parity_d = w_frame_par;
      out_beats_d  = w_cnt_inc;
      out_ovf_d    = w_ovf_inc;
`ifdef PARITY_CHECK_EN
      out_err_d    = (w_frame_par != in_exp_parity_i);
`endif
    end else if (w_out_acc) begin
      out_valid_d  = 1'b0;
    end
  end

  // State and datapath registers. An asynchronous reset drops any partial frame.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
      out_beats_q  <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
      out_beats_q  <= out_beats_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

`ifdef PARITY_CHECK_EN
  // Mismatch flag, registered together with out_parity.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_err_q <= 1'b0;
    end else begin
      out_err_q <= out_err_d;
    end
  end

  assign out_err_o = out_err_q;
`endif

  assign in_ready_o     = w_in_ready;
  assign out_valid_o    = out_valid_q;
  assign out_parity_o   = out_parity_q;
  assign out_beats_o    = out_beats_q;
  assign out_overflow_o = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_frame_accum
// Description : Directed self-checking bench for parity_frame_accum
//               (DATA_W=8, MAX_BEATS=4). Expected values are hand-computed.
//               The bench honours the PARITY_CHECK_EN macro. When the macro is
//               defined, the DUT is built with ODD=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_accum;

  localparam int DATA_W    = 8;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);
`ifdef PARITY_CHECK_EN
  localparam int ODD       = 1;
`else
  localparam int ODD       = 0;
`endif
  localparam logic [31:0] PO = ODD;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic              out_parity;
  logic [CNT_W-1:0]  out_beats;
  logic              out_overflow;
`ifdef PARITY_CHECK_EN
  logic              in_exp_parity;
  logic              out_err;
`endif

  int n_checks;
  int n_errors;

  parity_frame_accum #(
    .DATA_W    (DATA_W),
    .ODD       (ODD),
    .MAX_BEATS (MAX_BEATS)
  ) u_dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_data_i       (in_data),
    .in_last_i       (in_last),
`ifdef PARITY_CHECK_EN
    .in_exp_parity_i (in_exp_parity),
    .out_err_o       (out_err),
`endif
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_parity_o    (out_parity),
    .out_beats_o     (out_beats),
    .out_overflow_o  (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge. Outputs are sampled there and inputs change there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for one cycle, then drop in_valid.
  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Check the result port fields.
  task automatic chk_out(input string tag, input logic [31:0] v, input logic [31:0] p,
                         input logic [31:0] b, input logic [31:0] o);
    chk({tag, ".valid"}, 32'(out_valid), v);
    chk({tag, ".parity"}, 32'(out_parity), p);
    chk({tag, ".beats"}, 32'(out_beats), b);
    chk({tag, ".ovf"}, 32'(out_overflow), o);
  endtask

  // Accept the pending result and check that the port goes idle.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chk({tag, ".drained"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
`ifdef PARITY_CHECK_EN
    in_exp_parity = 1'b0;
`endif
    step();
    step();
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
`ifdef PARITY_CHECK_EN
    chk("reset.err", 32'(out_err), 32'd0);
`endif
    reset = 1'b0;
    step();

    // 1: a single-beat frame of 0xA5 (four ones).
    send(8'hA5, 1'b1);
    chk_out("t1", 1, 0 ^ PO, 1, 0);
    drain("t1");

    // 2: frame 01,02,07 sent back to back. The three bits are 1,1,1, so the parity is 1.
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    chk("t2.mid_valid", 32'(out_valid), 32'd0);
    send(8'h07, 1'b1);
    chk_out("t2", 1, 1 ^ PO, 3, 0);

    // 3: backpressure. The result is held and the input is refused for 5 cycles.
    chk("t3.in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("t3.hold", 1, 1 ^ PO, 3, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain("t3");

    // 4: a frame closes in the same cycle as the result is accepted.
    send(8'h01, 1'b0);
    send(8'h00, 1'b1);
    chk_out("t4.pre", 1, 1 ^ PO, 2, 0);
    out_ready = 1'b1;
    send(8'hFF, 1'b1);
    chk_out("t4", 1, 0 ^ PO, 1, 0);
    step();
    out_ready = 1'b0;
    chk("t4.drained", 32'(out_valid), 32'd0);

    // 5: six beats of 0x80. The count saturates at 4 and the frame overflows. Six ones give parity 0.
    for (int i = 0; i < 6; i++) send(8'h80, (i == 5));
    chk_out("t5", 1, 0 ^ PO, 4, 1);
    drain("t5");
    // Exactly MAX_BEATS beats is not an overflow.
    for (int i = 0; i < 4; i++) send(8'h80, (i == 3));
    chk_out("t5b", 1, 0 ^ PO, 4, 0);
    drain("t5b");

    // 6: a reset in the middle of a frame discards the partial accumulation (acc=1, cnt=2).
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    reset = 1'b1;
    #1;
    chk_out("t6.reset", 0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();
`ifdef PARITY_CHECK_EN
    in_exp_parity = 1'b1;
`endif
    send(8'h01, 1'b1);
    chk_out("t6", 1, 1 ^ PO, 1, 0);
`ifdef PARITY_CHECK_EN
    // ODD=1 makes the computed parity 0. It differs from the expected 1, so out_err is set.
    chk("t6.err", 32'(out_err), 32'd1);
    in_exp_parity = 1'b0;
`endif
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
